// File: rtl/vehicle_detect_queue.sv
// vehicle_detect_queue
//   Debounces a country-road loop sensor, counts waiting vehicles and
//   retires one vehicle per PASS_CYCLES of country green. Raises the
//   car-waiting request x while any vehicle is queued.
//
// Ports
//   clk      in   system clock, rising edge
//   clear    in   asynchronous active-low reset
//   loop_raw in   loop sensor, asynchronous and possibly bouncing
//   cntry    in   [1:0] country lamp: 0=RED 1=YELLOW 2=GREEN (3 = not green)
//   x        out  car-waiting request (registered)
//   q_count  out  [CNT_W-1:0] number of queued vehicles
//   sat      out  sticky: an arrival was lost at a full queue
//   fault    out  stuck-sensor flag (only with VDQ_STUCK_DET_EN defined)
//
// Build option
//   VDQ_STUCK_DET_EN : adds the stuck-sensor counter, the fault port and
//                      forces x high while fault is set.
//
// Debounce FSM states
//   state  | meaning
//   S_LOW  | sensor accepted low, idle
//   S_RISE | sensor went high, counting stable high samples
//   S_HIGH | sensor accepted high (vehicle present)
//   S_FALL | sensor went low, counting stable low samples

module vehicle_detect_queue #(
  parameter int DEB_CYCLES   = 4,
  parameter int PASS_CYCLES  = 8,
  parameter int CNT_W        = 4,
  parameter int STUCK_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             loop_raw,
  input  logic [1:0]       cntry,
  output logic             x,
  output logic [CNT_W-1:0] q_count,
  output logic             sat
`ifdef VDQ_STUCK_DET_EN
  ,
  output logic             fault
`endif
);

  localparam logic [1:0] S_LOW  = 2'd0;
  localparam logic [1:0] S_RISE = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_FALL = 2'd3;

  localparam logic [7:0]       DEB_LAST  = 8'(DEB_CYCLES - 1);
  localparam logic [7:0]       PASS_LAST = 8'(PASS_CYCLES - 1);
  localparam logic [CNT_W-1:0] Q_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] Q_MAX     = {CNT_W{1'b1}};

  logic [1:0]       sync_q, sync_d;
  logic             loop_s;
  logic [1:0]       state_q, state_d;
  logic [7:0]       deb_cnt_q, deb_cnt_d;
  logic             arrive_q, arrive_d;
  logic [7:0]       pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] q_count_q, q_count_d;
  logic             x_q, x_d;
  logic             sat_q, sat_d;
  logic             service_en;
  logic             depart;

  // Two-flop synchronizer; bit 1 is the synchronized sensor.
  always_comb begin
    sync_d = {sync_q[0], loop_raw};
  end
  assign loop_s = sync_q[1];

  // Debounce FSM. arrive is registered so one vehicle yields exactly one
  // single-cycle pulse, launched on the S_RISE -> S_HIGH edge only.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    arrive_d  = 1'b0;
    case (state_q)
      S_LOW: begin
        if (loop_s) begin
          state_d   = S_RISE;
          deb_cnt_d = 8'd1;
        end
      end
      S_RISE: begin
        if (!loop_s) begin
          state_d   = S_LOW;
          deb_cnt_d = 8'd0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = S_HIGH;
          deb_cnt_d = 8'd0;
          arrive_d  = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 8'd1;
        end
      end
      S_HIGH: begin
        if (!loop_s) begin
          state_d   = S_FALL;
          deb_cnt_d = 8'd1;
        end
      end
      S_FALL: begin
        if (loop_s) begin
          state_d   = S_HIGH;
          deb_cnt_d = 8'd0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = S_LOW;
          deb_cnt_d = 8'd0;
        end else begin
          deb_cnt_d = deb_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = S_LOW;
        deb_cnt_d = 8'd0;
      end
    endcase
  end

  // Pass timer: any non-green cycle (including code 3) or empty queue
  // throws away partial service.
  always_comb begin
    service_en = (cntry == 2'd2) && (q_count_q != '0);
    depart     = service_en && (pass_cnt_q == PASS_LAST);
    if (!service_en || depart) begin
      pass_cnt_d = 8'd0;
    end else begin
      pass_cnt_d = pass_cnt_q + 8'd1;
    end
  end

  // Queue counter. depart already implies a non-empty queue.
  always_comb begin
    q_count_d = q_count_q;
    sat_d     = sat_q;
    case ({arrive_q, depart})
      2'b10: begin
        if (q_count_q == Q_MAX) begin
          sat_d = 1'b1;
        end else begin
          q_count_d = q_count_q + Q_ONE;
        end
      end
      2'b01:   q_count_d = q_count_q - Q_ONE;
      default: q_count_d = q_count_q;
    endcase
  end

`ifdef VDQ_STUCK_DET_EN
  localparam logic [15:0] STUCK_LIM = 16'(STUCK_CYCLES);

  logic [15:0] stuck_cnt_q, stuck_cnt_d;
  logic        fault_q, fault_d;

  // Counter saturates so a very long stuck period cannot wrap and drop fault.
  always_comb begin
    if (state_q == S_HIGH) begin
      stuck_cnt_d = (stuck_cnt_q == 16'hFFFF) ? stuck_cnt_q : stuck_cnt_q + 16'd1;
    end else begin
      stuck_cnt_d = 16'd0;
    end
    fault_d = (state_q == S_HIGH) && (fault_q || (stuck_cnt_d >= STUCK_LIM));
    x_d     = (q_count_d != '0) || fault_d;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      stuck_cnt_q <= 16'd0;
      fault_q     <= 1'b0;
    end else begin
      stuck_cnt_q <= stuck_cnt_d;
      fault_q     <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  always_comb begin
    x_d = (q_count_d != '0);
  end
`endif

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sync_q     <= 2'b00;
      state_q    <= S_LOW;
      deb_cnt_q  <= 8'd0;
      arrive_q   <= 1'b0;
      pass_cnt_q <= 8'd0;
      q_count_q  <= '0;
      x_q        <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      arrive_q   <= arrive_d;
      pass_cnt_q <= pass_cnt_d;
      q_count_q  <= q_count_d;
      x_q        <= x_d;
      sat_q      <= sat_d;
    end
  end

  assign x       = x_q;
  assign q_count = q_count_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_vehicle_detect_queue.sv
// Testbench for vehicle_detect_queue (default parameters, CNT_W=4).
// Every q_count change seen on a falling clock edge is matched against the
// next value in a queue of expected counts pushed as stimulus is driven.
module tb_vehicle_detect_queue;

  logic       clk;
  logic       clear;
  logic       loop_raw;
  logic [1:0] cntry;
  logic       x;
  logic [3:0] q_count;
  logic       sat;
`ifdef VDQ_STUCK_DET_EN
  logic       fault;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] last_q = 4'd0;

`ifdef VDQ_STUCK_DET_EN
  vehicle_detect_queue #(
    .DEB_CYCLES(4), .PASS_CYCLES(8), .CNT_W(4), .STUCK_CYCLES(32)
  ) dut (
    .clk(clk), .clear(clear), .loop_raw(loop_raw), .cntry(cntry),
    .x(x), .q_count(q_count), .sat(sat), .fault(fault)
  );
`else
  vehicle_detect_queue #(
    .DEB_CYCLES(4), .PASS_CYCLES(8), .CNT_W(4), .STUCK_CYCLES(1024)
  ) dut (
    .clk(clk), .clear(clear), .loop_raw(loop_raw), .cntry(cntry),
    .x(x), .q_count(q_count), .sat(sat)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Advance n cycles, sampling on falling edges; every q_count change
  // must match the next scoreboard entry.
  task automatic step(input int n);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (q_count !== last_q) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_change", 32'(q_count), 32'(last_q));
        end else begin
          e = exp_q.pop_front();
          chk("sb_q_count", 32'(q_count), 32'(e));
          chk("sb_x", 32'(x), 32'(e != 4'd0));
        end
        last_q = q_count;
      end
    end
  endtask

  task automatic vehicle();
    loop_raw = 1'b1;
    step(8);
    loop_raw = 1'b0;
    step(8);
  endtask

  initial begin
    clear    = 1'b0;
    loop_raw = 1'b0;
    cntry    = 2'd0;
    #12;
    chk("reset_q_count", 32'(q_count), 32'd0);
    chk("reset_x", 32'(x), 32'd0);
    chk("reset_sat", 32'(sat), 32'd0);
`ifdef VDQ_STUCK_DET_EN
    chk("reset_fault", 32'(fault), 32'd0);
`endif
    @(negedge clk);
    clear = 1'b1;

    // Bounce: toggling every 2 cycles never gets through debounce.
    for (int i = 0; i < 10; i++) begin
      loop_raw = ~loop_raw;
      step(2);
      chk("bounce_q", 32'(q_count), 32'd0);
      chk("bounce_x", 32'(x), 32'd0);
    end
    loop_raw = 1'b0;
    step(10);
    chk("bounce_final_q", 32'(q_count), 32'd0);

    // Clean pulse: update exactly at edge k+6.
    loop_raw = 1'b1;
    exp_q.push_back(4'd1);
    for (int j = 1; j <= 6; j++) begin
      step(1);
      chk("latency_early_q", 32'(q_count), 32'd0);
    end
    step(1);
    chk("latency_q", 32'(q_count), 32'd1);
    chk("latency_x", 32'(x), 32'd1);
    step(3);
    loop_raw = 1'b0;
    step(30);
    chk("clean_hold_q", 32'(q_count), 32'd1);

    // Second vehicle.
    exp_q.push_back(4'd2);
    vehicle();
    chk("second_q", 32'(q_count), 32'd2);

    // Partial green, then yellow: no departure, timer restarts.
    cntry = 2'd2;
    step(5);
    cntry = 2'd1;
    step(3);
    chk("svc_partial_q", 32'(q_count), 32'd2);
    cntry = 2'd2;
    exp_q.push_back(4'd1);
    step(7);
    chk("svc_pre_first_q", 32'(q_count), 32'd2);
    step(1);
    chk("svc_first_q", 32'(q_count), 32'd1);
    chk("svc_first_x", 32'(x), 32'd1);
    exp_q.push_back(4'd0);
    step(7);
    chk("svc_pre_second_q", 32'(q_count), 32'd1);
    step(1);
    chk("svc_second_q", 32'(q_count), 32'd0);
    chk("svc_second_x", 32'(x), 32'd0);
    cntry = 2'd0;
    step(2);

    // cntry=3 is not green.
    exp_q.push_back(4'd1);
    vehicle();
    cntry = 2'd3;
    step(20);
    chk("cntry3_q", 32'(q_count), 32'd1);
    cntry = 2'd0;

    // Fill to full.
    for (int k = 2; k <= 15; k++) begin
      exp_q.push_back(4'(k));
      vehicle();
    end
    chk("full_q", 32'(q_count), 32'd15);
    chk("full_sat", 32'(sat), 32'd0);

    // Arrive and depart on the same edge at full: unchanged, no sat.
    cntry = 2'd2;
    step(1);
    loop_raw = 1'b1;
    step(8);
    chk("simul_q", 32'(q_count), 32'd15);
    chk("simul_sat", 32'(sat), 32'd0);
    cntry = 2'd0;
    loop_raw = 1'b0;
    step(10);
    chk("simul_hold_q", 32'(q_count), 32'd15);
    chk("simul_hold_sat", 32'(sat), 32'd0);

    // Arrival at full with no departure sets sat.
    vehicle();
    chk("sat_set", 32'(sat), 32'd1);
    chk("sat_q", 32'(q_count), 32'd15);
    chk("sat_x", 32'(x), 32'd1);
    chk("sb_empty_before_reset", 32'(exp_q.size()), 32'd0);

    // Reset mid-service and mid-S_RISE.
    cntry = 2'd2;
    step(3);
    loop_raw = 1'b1;
    step(3);
    #2;
    clear = 1'b0;
    #1;
    chk("async_reset_q", 32'(q_count), 32'd0);
    chk("async_reset_x", 32'(x), 32'd0);
    chk("async_reset_sat", 32'(sat), 32'd0);
`ifdef VDQ_STUCK_DET_EN
    chk("async_reset_fault", 32'(fault), 32'd0);
`endif
    last_q = 4'd0;
    cntry  = 2'd0;
    @(negedge clk);
    clear = 1'b1;

    // Sensor still high: full debounce restarts from the release.
    exp_q.push_back(4'd1);
    for (int j = 1; j <= 6; j++) begin
      step(1);
      chk("post_reset_early_q", 32'(q_count), 32'd0);
    end
    step(1);
    chk("post_reset_q", 32'(q_count), 32'd1);
    chk("post_reset_x", 32'(x), 32'd1);
    loop_raw = 1'b0;
    step(10);

`ifdef VDQ_STUCK_DET_EN
    exp_q.push_back(4'd2);
    loop_raw = 1'b1;
    step(40);
    chk("stuck_fault_set", 32'(fault), 32'd1);
    chk("stuck_x", 32'(x), 32'd1);
    loop_raw = 1'b0;
    step(4);
    chk("stuck_fault_clear", 32'(fault), 32'd0);
    step(6);
`endif

    chk("sb_empty_final", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
